// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/flush/PC-select controller for a 5-stage RISC-V pipeline.
// Handles load-use bubbles, EX/MEM redirects, and data-memory wait states with a timeout.
// Optional macro HAZARD_PERF_EN adds saturating stall_cnt/flush_cnt performance counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; memory wait, redirect, load-use decoded here
// MEM_WAIT | data access outstanding; pipeline frozen until ready/timeout
module hazard_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_lw,
  input  logic             exmem_lw,
  input  logic             exmem_EscMem,
  input  logic             exmem_jump,
  input  logic             exmem_jalr,
  input  logic             exmem_Branch,
  input  logic             exmem_cond,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_stall,
  output logic             pc_sel,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mem_err,
  output logic             busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     r_state, w_next;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_mem_err, w_err_set;
  logic       w_mem_acc, w_redirect, w_lu;
  logic       w_req, w_pc_stall, w_pc_sel, w_ifid_stall, w_ifid_flush;
  logic       w_idex_stall, w_idex_flush, w_exmem_stall, w_exmem_flush;
  logic       w_memwb_flush, w_busy;

  assign w_mem_acc  = exmem_lw | exmem_EscMem;
  assign w_redirect = exmem_jump | exmem_jalr | (exmem_Branch & exmem_cond);
  assign w_lu       = idex_lw && (idex_rd != 5'd0) &&
                      ((idex_rd == id_rs1) || (id_uses_rs2 && (idex_rd == id_rs2)));

  // State, wait counter and sticky error register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= RUN;
      r_cnt     <= 8'd0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_err_set) r_mem_err <= 1'b1;
    end
  end

  // Next-state and pipeline control decode; memory wait beats redirect beats load-use
  always_comb begin
    w_next        = r_state;
    w_cnt_nxt     = r_cnt;
    w_err_set     = 1'b0;
    w_req         = 1'b0;
    w_pc_stall    = 1'b0;
    w_pc_sel      = 1'b0;
    w_ifid_stall  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_stall  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_stall = 1'b0;
    w_exmem_flush = 1'b0;
    w_memwb_flush = 1'b0;
    w_busy        = 1'b0;
    case (r_state)
      RUN: begin
        w_req = w_mem_acc;
        if (w_mem_acc && !dmem_ready) begin
          w_pc_stall    = 1'b1;
          w_ifid_stall  = 1'b1;
          w_idex_stall  = 1'b1;
          w_exmem_stall = 1'b1;
          w_memwb_flush = 1'b1;
          w_next        = MEM_WAIT;
          w_cnt_nxt     = 8'd1;
        end else if (w_redirect) begin
          w_pc_sel      = 1'b1;
          w_ifid_flush  = 1'b1;
          w_idex_flush  = 1'b1;
          w_exmem_flush = 1'b1;
        end else if (w_lu) begin
          w_pc_stall   = 1'b1;
          w_ifid_stall = 1'b1;
          w_idex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        w_req  = 1'b1;
        w_busy = 1'b1;
        if (dmem_ready) begin
          w_next    = RUN;
          w_cnt_nxt = 8'd0;
        end else if (r_cnt == TIMEOUT) begin
          // abandon the access: release the pipe and retire it as a bubble
          w_err_set     = 1'b1;
          w_memwb_flush = 1'b1;
          w_next        = RUN;
          w_cnt_nxt     = 8'd0;
        end else begin
          w_pc_stall    = 1'b1;
          w_ifid_stall  = 1'b1;
          w_idex_stall  = 1'b1;
          w_exmem_stall = 1'b1;
          w_memwb_flush = 1'b1;
          w_cnt_nxt     = r_cnt + 8'd1;
        end
      end
      default: w_next = RUN;
    endcase
  end

  // Outputs are forced low while reset is held, independent of the inputs
  assign dmem_req    = reset_n & w_req;
  assign pc_stall    = reset_n & w_pc_stall;
  assign pc_sel      = reset_n & w_pc_sel;
  assign ifid_stall  = reset_n & w_ifid_stall;
  assign ifid_flush  = reset_n & w_ifid_flush;
  assign idex_stall  = reset_n & w_idex_stall;
  assign idex_flush  = reset_n & w_idex_flush;
  assign exmem_stall = reset_n & w_exmem_stall;
  assign exmem_flush = reset_n & w_exmem_flush;
  assign memwb_flush = reset_n & w_memwb_flush;
  assign mem_err     = reset_n & r_mem_err;
  assign busy        = reset_n & w_busy;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  // Saturating counts of stalled and redirected cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (pc_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (pc_sel && (r_flush_cnt != '1))   r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: directed scenarios plus random traffic, all checked
// cycle by cycle against a pipeline-action reference model.
module tb_hazard_sequencer;
  localparam int TO    = 4;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic [4:0] id_rs1, id_rs2, idex_rd;
  logic id_uses_rs2, idex_lw, exmem_lw, exmem_EscMem, exmem_jump, exmem_jalr;
  logic exmem_Branch, exmem_cond, dmem_ready;
  logic dmem_req, pc_stall, pc_sel, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic exmem_stall, exmem_flush, memwb_flush, mem_err, busy;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  hazard_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .idex_rd(idex_rd), .idex_lw(idex_lw),
    .exmem_lw(exmem_lw), .exmem_EscMem(exmem_EscMem), .exmem_jump(exmem_jump),
    .exmem_jalr(exmem_jalr), .exmem_Branch(exmem_Branch), .exmem_cond(exmem_cond),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req), .pc_stall(pc_stall), .pc_sel(pc_sel),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_stall(idex_stall),
    .idex_flush(idex_flush), .exmem_stall(exmem_stall), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .mem_err(mem_err), .busy(busy)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // observed vector, order:
  // req pc_stall pc_sel ifid_st ifid_fl idex_st idex_fl exmem_st exmem_fl memwb_fl err busy
  logic [11:0] obs;
  assign obs = {dmem_req, pc_stall, pc_sel, ifid_stall, ifid_flush, idex_stall, idex_flush,
                exmem_stall, exmem_flush, memwb_flush, mem_err, busy};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: memory outstanding flag, cycles spent waiting, sticky error
  bit      m_waiting;
  int      m_wait_cycles;
  bit      m_err;
  longint  m_stalls, m_flushes;
  longint  sat_max = (64'd1 << CNT_W) - 1;

  function automatic logic [11:0] model_out();
    bit acc, redir, lu, freeze, bubble, kill3, single;
    bit req;
    acc   = exmem_lw || exmem_EscMem;
    redir = exmem_jump || exmem_jalr || (exmem_Branch && exmem_cond);
    lu    = idex_lw && idex_rd != 0 &&
            (idex_rd == id_rs1 || (id_uses_rs2 && idex_rd == id_rs2));
    freeze = 0; bubble = 0; kill3 = 0; single = 0; req = 0;
    if (m_waiting) begin
      req = 1;
      if (!dmem_ready && m_wait_cycles < TO) begin freeze = 1; bubble = 1; end
      else if (!dmem_ready) bubble = 1;
    end else begin
      req = acc;
      if (acc && !dmem_ready) begin freeze = 1; bubble = 1; end
      else if (redir) kill3 = 1;
      else if (lu) single = 1;
    end
    return {req, freeze | single, kill3, freeze | single, kill3, freeze, kill3 | single,
            freeze, kill3, bubble, m_err, m_waiting};
  endfunction

  task automatic model_step(input logic [11:0] e);
    if (e[10] && m_stalls  < sat_max) m_stalls++;
    if (e[9]  && m_flushes < sat_max) m_flushes++;
    if (m_waiting) begin
      if (dmem_ready) m_waiting = 0;
      else if (m_wait_cycles == TO) begin m_waiting = 0; m_err = 1; end
      else m_wait_cycles++;
    end else if ((exmem_lw || exmem_EscMem) && !dmem_ready) begin
      m_waiting = 1;
      m_wait_cycles = 1;
    end
  endtask

  task automatic model_reset();
    m_waiting = 0; m_wait_cycles = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
  endtask

  // inputs already driven just after a negedge; check, advance model, reach next negedge
  task automatic step(input string tag);
    logic [11:0] e;
    #1;
    e = model_out();
    check(tag, obs, e);
`ifdef HAZARD_PERF_EN
    check({tag, "_scnt"}, stall_cnt, m_stalls);
    check({tag, "_fcnt"}, flush_cnt, m_flushes);
`endif
    model_step(e);
    @(negedge clk);
  endtask

  task automatic clear_in();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; idex_rd = 0; idex_lw = 0;
    exmem_lw = 0; exmem_EscMem = 0; exmem_jump = 0; exmem_jalr = 0;
    exmem_Branch = 0; exmem_cond = 0; dmem_ready = 0;
  endtask

  int n_busy, n_req, n_stall, n_wait;
  bit seen_busy;
  longint s0, f0;

  initial begin
    clear_in();
    reset_n = 0;
    model_reset();
    @(negedge clk);
    // active inputs under reset must not leak to the outputs
    exmem_lw = 1; exmem_jump = 1; idex_lw = 1; idex_rd = 3; id_rs1 = 3;
    #1 check("reset_outputs", obs, 12'h000);
    @(negedge clk);
    clear_in();
    reset_n = 1;
    step("idle");

    // load-use single bubble, then rd = x0 never stalls
    idex_lw = 1; idex_rd = 5; id_rs1 = 5;
    step("lu");
    idex_rd = 0;
    #1 check("lu_rd0_pcstall", pc_stall, 1'b0);
    step("lu_rd0");
    idex_rd = 7; id_rs1 = 1; id_rs2 = 7; id_uses_rs2 = 1;
    step("lu_rs2");
    clear_in();

    // taken branch outranks a simultaneous load-use
    s0 = m_flushes;
    idex_lw = 1; idex_rd = 5; id_rs1 = 5; exmem_Branch = 1; exmem_cond = 1;
    #1 check("br_taken_pcstall", pc_stall, 1'b0);
    check("br_taken_pcsel", pc_sel, 1'b1);
    step("br_taken");
`ifdef HAZARD_PERF_EN
    #1 check("perf_flush_delta", flush_cnt - s0[CNT_W-1:0], 1);
    @(negedge clk);
    step("br_after");
`endif
    clear_in();
    exmem_Branch = 1; exmem_cond = 0;
    #1 check("br_not_taken", obs, 12'h000);
    step("br_nt");
    clear_in();

    // three wait states then ready
    s0 = m_stalls;
    n_busy = 0; n_req = 0; n_stall = 0;
    exmem_lw = 1;
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      #1;
      n_busy += busy; n_req += dmem_req; n_stall += pc_stall;
      if (i == 3) check("ready_memwb_flush", memwb_flush, 1'b0);
      step("wait_seq");
    end
    clear_in();
    check("wait_busy_cycles", n_busy, 3);
    check("wait_req_cycles", n_req, 4);
    check("wait_stall_cycles", n_stall, 3);
    step("wait_done");
`ifdef HAZARD_PERF_EN
    check("perf_stall_delta", m_stalls - s0, 3);
`endif

    // zero-wait store
    exmem_EscMem = 1; dmem_ready = 1;
    #1 check("zw_req", dmem_req, 1'b1);
    check("zw_stall", pc_stall, 1'b0);
    step("zero_wait");
    clear_in();
    #1 check("zw_busy", busy, 1'b0);
    step("zero_wait_after");

    // timeout: ready never comes
    exmem_lw = 1;
    step("to_start");
    exmem_lw = 0;
    n_wait = 0; seen_busy = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (busy) begin n_wait++; seen_busy = 1; end
      if (seen_busy && !busy) break;
      step("to_wait");
    end
    check("to_wait_cycles", n_wait, TO);
    check("to_err_set", mem_err, 1'b1);
    step("to_run");
    step("to_sticky");
    check("to_err_sticky", mem_err, 1'b1);
    reset_n = 0;
    #1 check("to_err_reset", mem_err, 1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1;
    step("post_reset");

    // reset while waiting drops everything asynchronously
    exmem_lw = 1;
    step("rw_enter");
    step("rw_wait");
    #2 reset_n = 0;
    #1 check("rw_async", obs, 12'h000);
    model_reset();
    @(negedge clk);
    clear_in();
    reset_n = 1;
    #1 check("rw_run", busy, 1'b0);
    step("rw_after");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      idex_rd      = 5'($urandom_range(0, 3));
      id_uses_rs2  = 1'($urandom_range(0, 1));
      idex_lw      = ($urandom_range(0, 2) == 0);
      exmem_lw     = ($urandom_range(0, 7) == 0);
      exmem_EscMem = ($urandom_range(0, 7) == 0);
      exmem_jump   = ($urandom_range(0, 9) == 0);
      exmem_jalr   = ($urandom_range(0, 9) == 0);
      exmem_Branch = ($urandom_range(0, 3) == 0);
      exmem_cond   = 1'($urandom_range(0, 1));
      dmem_ready   = ($urandom_range(0, 2) != 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
